// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Program-counter sequencer for a simple instruction fetch front end.
// A three-state controller (IDLE / RUN / HALTED) owns the PC and a
// circular return-address stack. In RUN exactly one action is applied per
// cycle, in priority order:
//   Start > Halt > Stall > Ret > Call > Jump > taken Branch > PC+1
// All PC arithmetic wraps modulo 2^PW.
//
// Ports
//   CLK            in   sole clock, rising edge
//   reset          in   asynchronous, active-low reset
//   Start          in   load Start_Address and enter RUN
//   Start_Address  in   [PW]  program entry point
//   Halt           in   stop fetching (RUN -> HALTED)
//   Stall          in   hold PC for one cycle
//   Branch         in   conditional relative branch request
//   BranchCond     in   branch condition (taken when Branch & BranchCond)
//   Offset         in   [PW]  signed two's-complement branch offset
//   Jump           in   absolute jump to Target
//   Call           in   push PC+1 and jump to Target
//   Ret            in   pop return address into PC
//   Target         in   [PW]  destination for Jump / Call
//   PC             out  [PW]  current fetch address
//   running        out  high in RUN
//   done           out  high in HALTED
//   ras_count      out  occupied return-stack entries
//   ras_ovf        out  sticky: Call seen with the stack full
//   ras_unf        out  sticky: Ret seen with the stack empty
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int PW        = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic                           Start,
  input  logic [PW-1:0]                  Start_Address,
  input  logic                           Halt,
  input  logic                           Stall,
  input  logic                           Branch,
  input  logic                           BranchCond,
  input  logic [PW-1:0]                  Offset,
  input  logic                           Jump,
  input  logic                           Call,
  input  logic                           Ret,
  input  logic [PW-1:0]                  Target,
  output logic [PW-1:0]                  PC,
  output logic                           running,
  output logic                           done,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int CW   = $clog2(RAS_DEPTH + 1);
  localparam int PTRW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t                       r_state;
  logic [PW-1:0]                r_pc;
  logic                         r_running;
  logic                         r_done;
  logic [RAS_DEPTH-1:0][PW-1:0] r_stack;
  logic [PTRW-1:0]              r_wrPtr;
  logic [CW-1:0]                r_count;
  logic                         r_ovf;
  logic                         r_unf;

  logic [PW-1:0]                w_pcPlus1;
  logic [PW-1:0]                w_pcBranch;
  logic                         w_stackFull;
  logic                         w_stackEmpty;
  logic [PTRW-1:0]              w_pushNext;
  logic [PTRW-1:0]              w_popIdx;

  // Next-address candidates and stack pointer arithmetic. The write
  // pointer always names the slot the next push lands in; when the stack
  // is full that slot holds the oldest entry, so a push overwrites it.
  // Wrap is explicit so that non-power-of-two depths work.
  always_comb begin
    w_pcPlus1    = r_pc + PW'(1);
    w_pcBranch   = r_pc + Offset;
    w_stackFull  = (r_count == CW'(RAS_DEPTH));
    w_stackEmpty = (r_count == '0);
    w_pushNext   = (r_wrPtr == PTRW'(RAS_DEPTH - 1)) ? '0 : r_wrPtr + PTRW'(1);
    w_popIdx     = (r_wrPtr == '0) ? PTRW'(RAS_DEPTH - 1) : r_wrPtr - PTRW'(1);
  end

  // Controller, PC and return-address stack. Everything lives in one
  // clocked block so the action priority reads top to bottom; running and
  // done are registered alongside the state so no input reaches an output
  // combinationally.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_stack   <= '0;
      r_wrPtr   <= '0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
      r_unf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_pc      <= Start_Address;
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end

        S_RUN: begin
          if (Start) begin
            // Restart from a new entry point with a clean stack.
            r_pc    <= Start_Address;
            r_stack <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
          end else if (Halt) begin
            r_state   <= S_HALTED;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else if (Stall) begin
            // PC and stack hold, even if Call or Ret is also requested.
            r_pc <= r_pc;
          end else if (Ret) begin
            // Ret wins over a simultaneous Call; the Call is dropped.
            if (w_stackEmpty) begin
              r_pc  <= w_pcPlus1;
              r_unf <= 1'b1;
            end else begin
              r_pc    <= r_stack[w_popIdx];
              r_wrPtr <= w_popIdx;
              r_count <= r_count - CW'(1);
            end
          end else if (Call) begin
            r_stack[r_wrPtr] <= w_pcPlus1;
            r_wrPtr          <= w_pushNext;
            r_pc             <= Target;
            if (w_stackFull) begin
              r_ovf <= 1'b1;
            end else begin
              r_count <= r_count + CW'(1);
            end
          end else if (Jump) begin
            r_pc <= Target;
          end else if (Branch && BranchCond) begin
            r_pc <= w_pcBranch;
          end else begin
            r_pc <= w_pcPlus1;
          end
        end

        S_HALTED: begin
          if (Start) begin
            r_pc      <= Start_Address;
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_done    <= 1'b0;
            r_stack   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign PC        = r_pc;
  assign running   = r_running;
  assign done      = r_done;
  assign ras_count = r_count;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit (PW=16, RAS_DEPTH=4). A table of
// single-cycle vectors with hand-derived expectations, hand-written
// multi-cycle sequences (stack overflow/underflow, halt hold, async reset
// mid-Call), then randomized traffic checked against a queue-based model.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int PW    = 16;
  localparam int DEPTH = 4;

  logic          CLK;
  logic          resetN;
  logic          start;
  logic [PW-1:0] startAddr;
  logic          halt;
  logic          stall;
  logic          branch;
  logic          branchCond;
  logic [PW-1:0] offset;
  logic          jump;
  logic          call;
  logic          ret;
  logic [PW-1:0] target;
  logic [PW-1:0] pc;
  logic          running;
  logic          done;
  logic [2:0]    rasCount;
  logic          rasOvf;
  logic          rasUnf;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PW(PW), .RAS_DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .reset         (resetN),
    .Start         (start),
    .Start_Address (startAddr),
    .Halt          (halt),
    .Stall         (stall),
    .Branch        (branch),
    .BranchCond    (branchCond),
    .Offset        (offset),
    .Jump          (jump),
    .Call          (call),
    .Ret           (ret),
    .Target        (target),
    .PC            (pc),
    .running       (running),
    .done          (done),
    .ras_count     (rasCount),
    .ras_ovf       (rasOvf),
    .ras_unf       (rasUnf)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    string         name;
    logic          start;
    logic [PW-1:0] sa;
    logic          halt;
    logic          stall;
    logic          branch;
    logic          cond;
    logic [PW-1:0] offset;
    logic          jump;
    logic          call;
    logic          ret;
    logic [PW-1:0] target;
    logic [PW-1:0] ePc;
    logic          eRun;
    logic          eDone;
    logic [2:0]    eCnt;
    logic          eOvf;
    logic          eUnf;
  } vec_t;

  // Reference model: state 0=IDLE 1=RUN 2=HALTED, stack as a queue whose
  // back is the newest entry.
  int            mState;
  logic [PW-1:0] mPc;
  logic [PW-1:0] mStack[$];
  logic          mOvf;
  logic          mUnf;

  function automatic vec_t mk(string n, logic st, logic [PW-1:0] sa, logic h, logic sl,
                              logic br, logic c, logic [PW-1:0] off, logic j, logic ca,
                              logic r, logic [PW-1:0] t, logic [PW-1:0] ePc, logic eRun,
                              logic eDone, logic [2:0] eCnt, logic eOvf, logic eUnf);
    vec_t v;
    v.name = n; v.start = st; v.sa = sa; v.halt = h; v.stall = sl; v.branch = br;
    v.cond = c; v.offset = off; v.jump = j; v.call = ca; v.ret = r; v.target = t;
    v.ePc = ePc; v.eRun = eRun; v.eDone = eDone; v.eCnt = eCnt; v.eOvf = eOvf; v.eUnf = eUnf;
    return v;
  endfunction

  task automatic clearInputs();
    start = 0; startAddr = '0; halt = 0; stall = 0; branch = 0; branchCond = 0;
    offset = '0; jump = 0; call = 0; ret = 0; target = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    start = v.start; startAddr = v.sa; halt = v.halt; stall = v.stall;
    branch = v.branch; branchCond = v.cond; offset = v.offset; jump = v.jump;
    call = v.call; ret = v.ret; target = v.target;
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s %s: got %h expected %h", tag, field, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [PW-1:0] ePc, input logic eRun,
                             input logic eDone, input logic [2:0] eCnt, input logic eOvf,
                             input logic eUnf);
    cmp(tag, "PC",        32'(pc),       32'(ePc));
    cmp(tag, "running",   32'(running),  32'(eRun));
    cmp(tag, "done",      32'(done),     32'(eDone));
    cmp(tag, "ras_count", 32'(rasCount), 32'(eCnt));
    cmp(tag, "ras_ovf",   32'(rasOvf),   32'(eOvf));
    cmp(tag, "ras_unf",   32'(rasUnf),   32'(eUnf));
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, mPc, mState == 1, mState == 2, 3'(mStack.size()), mOvf, mUnf);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic modelReset();
    mState = 0; mPc = '0; mStack.delete(); mOvf = 0; mUnf = 0;
  endtask

  task automatic modelClear();
    mStack.delete(); mOvf = 0; mUnf = 0;
  endtask

  // One cycle of the fetch rules applied to the current tb inputs.
  task automatic modelStep();
    case (mState)
      0: if (start) begin mPc = startAddr; mState = 1; end
      1: begin
        if (start) begin mPc = startAddr; modelClear(); end
        else if (halt) mState = 2;
        else if (stall) begin end
        else if (ret) begin
          if (mStack.size() > 0) mPc = mStack.pop_back();
          else begin mPc = mPc + 16'd1; mUnf = 1; end
        end else if (call) begin
          mStack.push_back(mPc + 16'd1);
          if (mStack.size() > DEPTH) begin
            void'(mStack.pop_front());
            mOvf = 1;
          end
          mPc = target;
        end else if (jump) mPc = target;
        else if (branch && branchCond) mPc = mPc + offset;
        else mPc = mPc + 16'd1;
      end
      default: if (start) begin mPc = startAddr; mState = 1; modelClear(); end
    endcase
  endtask

  task automatic doReset();
    clearInputs();
    @(negedge CLK);
    resetN = 0;
    repeat (2) @(negedge CLK);
    resetN = 1;
    #1;
    modelReset();
  endtask

  vec_t vecs[21];

  initial begin
    resetN = 1;
    clearInputs();
    #2;
    doReset();

    // Reset state
    checkOutput("reset", 16'h0000, 0, 0, 3'd0, 0, 0);

    // Table of single-cycle vectors, applied back to back from reset.
    vecs[0]  = mk("idleIgnore",   0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h9999, 16'h0000, 0, 0, 0, 0, 0);
    vecs[1]  = mk("start100",     1, 16'h0100, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0100, 1, 0, 0, 0, 0);
    vecs[2]  = mk("inc1",         0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0101, 1, 0, 0, 0, 0);
    vecs[3]  = mk("inc2",         0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0102, 1, 0, 0, 0, 0);
    vecs[4]  = mk("inc3",         0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0103, 1, 0, 0, 0, 0);
    vecs[5]  = mk("start10",      1, 16'h0010, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0010, 1, 0, 0, 0, 0);
    vecs[6]  = mk("brTaken",      0, 16'h0000, 0, 0, 1, 1, 16'hFFF0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0);
    vecs[7]  = mk("start10b",     1, 16'h0010, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0010, 1, 0, 0, 0, 0);
    vecs[8]  = mk("brNotTaken",   0, 16'h0000, 0, 0, 1, 0, 16'hFFF0, 0, 0, 0, 16'h0000, 16'h0011, 1, 0, 0, 0, 0);
    vecs[9]  = mk("startFFFF",    1, 16'hFFFF, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'hFFFF, 1, 0, 0, 0, 0);
    vecs[10] = mk("wrap",         0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0);
    vecs[11] = mk("jump",         0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h1234, 16'h1234, 1, 0, 0, 0, 0);
    vecs[12] = mk("stallCall",    0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 16'h5555, 16'h1234, 1, 0, 0, 0, 0);
    vecs[13] = mk("callRetEmpty", 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 1, 16'h5555, 16'h1235, 1, 0, 0, 0, 1);
    vecs[14] = mk("call",         0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 16'h0300, 16'h0300, 1, 0, 1, 0, 1);
    vecs[15] = mk("stallRet",     0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0300, 1, 0, 1, 0, 1);
    vecs[16] = mk("jumpOverBr",   0, 16'h0000, 0, 0, 1, 1, 16'h0010, 1, 0, 0, 16'h0400, 16'h0400, 1, 0, 1, 0, 1);
    vecs[17] = mk("retPop",       0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h1236, 1, 0, 0, 0, 1);
    vecs[18] = mk("halt",         0, 16'h0000, 1, 0, 0, 0, 16'h0000, 1, 0, 0, 16'h7777, 16'h1236, 0, 1, 0, 0, 1);
    vecs[19] = mk("haltedIgnore", 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 1, 1, 0, 16'h7777, 16'h1236, 0, 1, 0, 0, 1);
    vecs[20] = mk("restart",      1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput(vecs[i].name, vecs[i].ePc, vecs[i].eRun, vecs[i].eDone,
                  vecs[i].eCnt, vecs[i].eOvf, vecs[i].eUnf);
    end

    // Stack overflow then underflow.
    doReset();
    start = 1; startAddr = 16'h0020;
    step();
    clearInputs();
    for (int i = 0; i < 5; i++) begin
      call = 1; target = 16'h0200 + 16'(i);
      step();
    end
    checkOutput("ovfCalls", 16'h0204, 1, 0, 3'd4, 1, 0);
    clearInputs();
    ret = 1;
    step(); checkOutput("pop1", 16'h0204, 1, 0, 3'd3, 1, 0);
    step(); checkOutput("pop2", 16'h0203, 1, 0, 3'd2, 1, 0);
    step(); checkOutput("pop3", 16'h0202, 1, 0, 3'd1, 1, 0);
    step(); checkOutput("pop4", 16'h0201, 1, 0, 3'd0, 1, 0);
    step(); checkOutput("popUnf", 16'h0202, 1, 0, 3'd0, 1, 1);
    clearInputs();

    // Halt holds PC for 10 cycles whatever else is driven; Start resumes.
    doReset();
    start = 1; startAddr = 16'h0041;
    step();
    clearInputs();
    ret = 1;
    step();
    clearInputs();
    checkOutput("preHalt", 16'h0042, 1, 0, 3'd0, 0, 1);
    halt = 1;
    step();
    checkOutput("halted", 16'h0042, 0, 1, 3'd0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      halt = 1'($urandom); stall = 1'($urandom); call = 1'($urandom);
      ret = 1'($urandom); jump = 1'($urandom); branch = 1;
      branchCond = 1; target = 16'($urandom); offset = 16'($urandom);
      step();
      cmp("haltHold", "PC", 32'(pc), 32'h0042);
      cmp("haltHold", "done", 32'(done), 32'd1);
    end
    clearInputs();
    start = 1; startAddr = 16'h0000;
    step();
    clearInputs();
    checkOutput("resume", 16'h0000, 1, 0, 3'd0, 0, 0);

    // Asynchronous reset in the middle of a Call cycle.
    doReset();
    start = 1; startAddr = 16'h0050;
    step();
    clearInputs();
    call = 1; target = 16'h0600;
    step();
    checkOutput("preReset", 16'h0600, 1, 0, 3'd1, 0, 0);
    #2;
    resetN = 0;
    #1;
    cmp("asyncReset", "PC", 32'(pc), 32'h0000);
    cmp("asyncReset", "ras_count", 32'(rasCount), 32'd0);
    cmp("asyncReset", "running", 32'(running), 32'd0);
    clearInputs();
    @(negedge CLK);
    resetN = 1;
    repeat (3) step();
    checkOutput("idleAfterReset", 16'h0000, 0, 0, 3'd0, 0, 0);

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 99) < 4);
      startAddr  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      halt       = ($urandom_range(0, 99) < 3);
      stall      = ($urandom_range(0, 99) < 15);
      ret        = ($urandom_range(0, 99) < 20);
      call       = ($urandom_range(0, 99) < 30);
      jump       = ($urandom_range(0, 99) < 10);
      branch     = ($urandom_range(0, 99) < 30);
      branchCond = 1'($urandom);
      offset     = 16'($urandom);
      target     = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      modelStep();
      step();
      checkModel("random");
    end
    clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PW, default 16, PC and address width in bits.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries (>=2).
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  load Start_Address and enter RUN.
REQ-006 Start_Address  input  PW  program entry point.
REQ-007 Halt  input  1  stop fetching.
REQ-008 Stall  input  1  hold PC for one cycle.
REQ-009 Branch  input  1  conditional relative branch request.
REQ-010 BranchCond  input  1  branch condition; the branch is taken only when Branch=1 and BranchCond=1.
REQ-011 Offset  input  PW  signed two's-complement branch offset.
REQ-012 Jump  input  1  absolute jump to Target.
REQ-013 Call  input  1  push return address, jump to Target.
REQ-014 Ret  input  1  pop return address into PC.
REQ-015 Target  input  PW  absolute destination for Jump/Call.
REQ-016 PC  output  PW  current fetch address.
REQ-017 running  output  1  high in state RUN.
REQ-018 done  output  1  high in state HALTED.
REQ-019 ras_count  output  clog2(RAS_DEPTH+1)  occupied stack entries.
REQ-020 ras_ovf  output  1  sticky; a Call occurred with the stack full.
REQ-021 ras_unf  output  1  sticky; a Ret occurred with the stack empty.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, RUN and HALTED.
REQ-023 IDLE: PC holds; Start=1 -> PC<=Start_Address and next state RUN; all other inputs are ignored.
REQ-024 RUN: exactly one action per cycle, in this priority order (highest first):
  - Start: PC<=Start_Address; stack, ras_ovf and ras_unf cleared.
  - Halt: next state HALTED; PC holds.
  - Stall: PC holds.
  - Ret: pop.
  - Call: push.
  - Jump: PC<=Target.
  - Taken branch: PC<=PC+Offset.
  - Otherwise: PC<=PC+1.
REQ-025 HALTED: PC holds; Start=1 -> PC<=Start_Address, next state RUN, stack, ras_ovf and ras_unf cleared; all other inputs are ignored.
REQ-026 All PC arithmetic SHALL be modulo 2^PW: 2^PW-1 + 1 -> 0, and a negative Offset wraps below 0.
REQ-027 A branch with Branch=1 and BranchCond=0 SHALL advance PC by +1.
REQ-028 Call SHALL push PC+1 (modulo 2^PW) and load PC<=Target in the same cycle.
REQ-029 Call with ras_count=RAS_DEPTH:
  - overwrites the oldest entry (circular);
  - ras_count stays at RAS_DEPTH;
  - ras_ovf<=1.
REQ-030 Ret with ras_count>0 SHALL load PC<=most recent entry and decrement ras_count.
REQ-031 Ret with ras_count=0 SHALL set PC<=PC+1 and ras_unf<=1.
REQ-032 Call and Ret asserted together SHALL perform only the Ret; the Call is dropped.
REQ-033 Stall=1 together with Call or Ret SHALL leave the stack unchanged.
REQ-034 The action for a cycle SHALL be visible on PC one cycle after the triggering edge (single-cycle latency).
REQ-035 Outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-036 reset=0 SHALL asynchronously force:
  - state IDLE;
  - PC=0;
  - running=0, done=0;
  - ras_count=0, ras_ovf=0, ras_unf=0;
  - all stack entries =0.
REQ-037 Asserting reset mid-RUN or mid-HALTED SHALL abandon all state with no further PC update.
REQ-038 After reset deasserts, the block SHALL remain in IDLE until Start=1.

Verification
REQ-039 Start with Start_Address=0x0100, then 3 idle cycles -> PC sequence 0x0100, 0x0101, 0x0102, 0x0103; running=1.
REQ-040 At PC=0x0010, Branch=1 and BranchCond=1 with Offset=0xFFF0 -> PC=0x0000; repeat with BranchCond=0 -> PC=0x0011.
REQ-041 PC=0xFFFF, no control input -> next PC=0x0000.
REQ-042 Stack overflow/underflow sequence:
  - Five Calls with Target=0x0200+i from PC=0x0020 (i=0..4) -> ras_count=4, ras_ovf=1.
  - Then five Rets -> four pops return the newest four addresses; the fifth Ret sets ras_unf=1 with PC+1.
REQ-043 Halt at PC=0x0042 -> done=1, PC stays 0x0042 for 10 cycles; Start with Start_Address=0x0000 -> running=1, flags cleared.
REQ-044 Assert reset=0 mid-Call -> PC=0 and ras_count=0 immediately, without waiting for a CLK edge.
